// File: rtl/adc_result_fifo_if.sv
// Result-side bus of the ADC readout buffer: conversion capture in, valid/ready word stream out.
// valid/ready: a word transfers on a rising clk edge where data_valid_out and data_ready_in are both 1;
// while data_valid_out=1 and data_ready_in=0 the FIFO holds data_out and data_valid_out stable.
interface adc_result_fifo_if #(
  parameter int MATRIX_BITS = 10
);
  logic                   conv_finished_strobe_in;
  logic [MATRIX_BITS-1:0] result_in;
  logic                   data_valid_out;
  logic [MATRIX_BITS-1:0] data_out;
  logic                   data_ready_in;

  // master: the surrounding system (ADC controller plus consumer); slave: the FIFO.
  modport master (
    output conv_finished_strobe_in, result_in, data_ready_in,
    input  data_valid_out, data_out
  );

  modport slave (
    input  conv_finished_strobe_in, result_in, data_ready_in,
    output data_valid_out, data_out
  );
endinterface

// File: rtl/adc_result_fifo.sv
// First-word-fall-through buffer for SAR ADC results with fill level, sticky overflow,
// level-threshold interrupt and a count of accepted samples.
module adc_result_fifo #(
  parameter int MATRIX_BITS = 10,
  parameter int FIFO_DEPTH  = 8,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_in,
  adc_result_fifo_if.slave     bus,
  output logic [AW:0]          level_out,
  input  logic [AW:0]          threshold_in,
  output logic                 threshold_irq_out,
  output logic                 overflow_out,
  input  logic                 overflow_clear_in,
  output logic [15:0]          sample_count_out
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

  logic [MATRIX_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            level;
  logic                   overflow;
  logic [15:0]            sample_count;

  logic push, pop, full, valid, accept, drop;

  assign push   = enable_in & bus.conv_finished_strobe_in;
  assign valid  = (level != '0);
  assign pop    = valid & bus.data_ready_in;
  assign full   = (level == FULL_LEVEL);
  // A pop frees the head slot in the same edge, so a push into a full FIFO still lands.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      sample_count <= '0;
    end else begin
      if (accept) begin
        wr_ptr       <= wr_ptr + AW'(1);
        sample_count <= sample_count + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (accept && !pop) begin
        level <= level + (AW+1)'(1);
      end else if (pop && !accept) begin
        level <= level - (AW+1)'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clear_in) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage cells are not reset; the pointers and level define what is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= bus.result_in;
    end
  end

  assign bus.data_valid_out = valid;
  assign bus.data_out       = valid ? mem[rd_ptr] : '0;
  assign level_out          = level;
  assign overflow_out       = overflow;
  assign sample_count_out   = sample_count;
  assign threshold_irq_out  = (threshold_in != '0) && (level >= threshold_in);

endmodule
